// File: rtl/alarm_clock_if.sv
// Button pulses in, BCD display digits and alarm status out, for alarm_clock_core.
interface alarm_clock_if #(
  parameter int NUM_ALARMS = 2
) ();
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;

  logic                  up, down, left, right, center;
  logic [1:0]            disp_h1;
  logic [3:0]            disp_h2;
  logic [2:0]            disp_m1;
  logic [3:0]            disp_m2;
  logic [3:0]            blink_mask;
  logic                  sec_led;
  logic [2:0]            mode;
  logic [AW-1:0]         sel_alarm;
  logic [NUM_ALARMS-1:0] alarm_en;
  logic                  ring;
  logic [AW-1:0]         ring_src;

  modport master (
    output up, down, left, right, center,
    input  disp_h1, disp_h2, disp_m1, disp_m2, blink_mask, sec_led,
    input  mode, sel_alarm, alarm_en, ring, ring_src
  );

  modport slave (
    input  up, down, left, right, center,
    output disp_h1, disp_h2, disp_m1, disp_m2, blink_mask, sec_led,
    output mode, sel_alarm, alarm_en, ring, ring_src
  );
endinterface

// File: rtl/alarm_clock_core.sv
// HH:MM:SS clock, five-state edit FSM and NUM_ALARMS alarms with ring/auto-silence.
// Optional snooze is compiled in with `define ALARM_SNOOZE_EN.

module alarm_clock_slot (
  input  logic [10:0] alarm,
  input  logic [10:0] now,
  input  logic        en,
  output logic        hit
);
  assign hit = en && (alarm == now);
endmodule

module alarm_clock_core #(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int NUM_ALARMS    = 2,
  parameter int RING_MIN      = 1,
  parameter int SNOOZE_MIN    = 5
) (
  input  logic          clk,
  input  logic          rst,
  alarm_clock_if.slave  bus
);
  localparam int AW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1;
  localparam int PW = $clog2(TICKS_PER_SEC);
  localparam logic [AW-1:0] LAST    = AW'(NUM_ALARMS - 1);
  localparam logic [PW-1:0] P_TERM  = PW'(TICKS_PER_SEC - 1);
  localparam logic [PW-1:0] P_HALF  = PW'(TICKS_PER_SEC / 2);
  localparam logic [5:0]    RING_LD = 6'(RING_MIN);

  if (TICKS_PER_SEC < 2 || (TICKS_PER_SEC % 2) != 0 || NUM_ALARMS < 1 || NUM_ALARMS > 8 ||
      RING_MIN < 1 || RING_MIN > 59 || SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_cfg_err
    $error("alarm_clock_core: parameter out of range");
  end

  typedef enum logic [2:0] {NORMAL = 3'd0, SET_TH = 3'd1, SET_TM = 3'd2,
                            SET_AH = 3'd3, SET_AM = 3'd4} mode_e;
  typedef enum logic [2:0] {B_NONE, B_CENTER, B_RIGHT, B_LEFT, B_UP, B_DOWN} btn_e;
  typedef struct packed {
    logic [4:0] hh;
    logic [5:0] mm;
  } hm_t;

  mode_e                  mode_q, mode_d;
  logic [AW-1:0]          sel_q, sel_d;
  logic [PW-1:0]          presc_q, presc_d, blink_q, blink_d;
  logic [5:0]             sec_q, sec_d;
  hm_t                    time_q, time_d, now_t, shown;
  hm_t [NUM_ALARMS-1:0]   alarm_q, alarm_d;
  logic [NUM_ALARMS-1:0]  en_q, en_d, hit;
  logic                   led_q, led_d, ring_q, ring_d;
  logic [AW-1:0]          src_q, src_d, fire_src;
  logic [5:0]             rcnt_q, rcnt_d;
  logic                   hold, tick, roll, fire, silence, is_up, is_dn;
  logic [3:0]             mask;
  btn_e                   btn;

  function automatic logic [4:0] hr_step(input logic [4:0] h, input logic inc);
    if (inc) hr_step = (h == 5'd23) ? 5'd0 : h + 5'd1;
    else     hr_step = (h == 5'd0) ? 5'd23 : h - 5'd1;
  endfunction

  function automatic logic [5:0] mn_step(input logic [5:0] m, input logic inc);
    if (inc) mn_step = (m == 6'd59) ? 6'd0 : m + 6'd1;
    else     mn_step = (m == 6'd0) ? 6'd59 : m - 6'd1;
  endfunction

  // Only the highest-priority pulse of a cycle acts.
  always_comb begin
    btn = B_NONE;
    if      (bus.center) btn = B_CENTER;
    else if (bus.right)  btn = B_RIGHT;
    else if (bus.left)   btn = B_LEFT;
    else if (bus.up)     btn = B_UP;
    else if (bus.down)   btn = B_DOWN;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q <= NORMAL;
      sel_q  <= '0;
    end else begin
      mode_q <= mode_d;
      sel_q  <= sel_d;
    end
  end

  always_comb begin
    mode_d = mode_q;
    sel_d  = sel_q;
    case (btn)
      B_CENTER: mode_d = (mode_q == NORMAL && !ring_q) ? SET_TH : NORMAL;
      B_RIGHT: begin
        case (mode_q)
          SET_TH: mode_d = SET_TM;
          SET_TM: mode_d = SET_AH;
          SET_AH: mode_d = SET_AM;
          SET_AM: begin
            if (sel_q == LAST) begin
              mode_d = SET_TH;
              sel_d  = '0;
            end else begin
              mode_d = SET_AH;
              sel_d  = sel_q + 1'b1;
            end
          end
          default: ;
        endcase
      end
      B_LEFT: begin
        case (mode_q)
          SET_TH: begin
            mode_d = SET_AM;
            sel_d  = LAST;
          end
          SET_TM: mode_d = SET_TH;
          SET_AH: begin
            if (sel_q == '0) mode_d = SET_TM;
            else begin
              mode_d = SET_AM;
              sel_d  = sel_q - 1'b1;
            end
          end
          SET_AM: mode_d = SET_AH;
          default: ;
        endcase
      end
      B_UP: if (mode_q == NORMAL && !ring_q) sel_d = (sel_q == LAST) ? '0 : sel_q + 1'b1;
      default: ;
    endcase
  end

  // Time after this cycle's tick, before any button edit; alarms compare against it.
  always_comb begin
    hold  = (mode_q == SET_TH) || (mode_q == SET_TM);
    tick  = !hold && (presc_q == P_TERM);
    roll  = tick && (sec_q == 6'd59);
    now_t = time_q;
    if (roll) begin
      now_t.mm = mn_step(time_q.mm, 1'b1);
      if (time_q.mm == 6'd59) now_t.hh = hr_step(time_q.hh, 1'b1);
    end
  end

  for (genvar k = 0; k < NUM_ALARMS; k++) begin : g_slot
    alarm_clock_slot u_slot (
      .alarm (alarm_q[k]),
      .now   (now_t),
      .en    (en_q[k]),
      .hit   (hit[k])
    );
  end

  always_comb begin
    fire_src = '0;
    for (int k = NUM_ALARMS - 1; k >= 0; k--)
      if (hit[k]) fire_src = AW'(k);
    fire = roll && (|hit);
  end

  always_comb begin
    presc_d = (hold || tick) ? '0 : presc_q + 1'b1;
    blink_d = (blink_q == P_TERM) ? '0 : blink_q + 1'b1;
    sec_d   = hold ? 6'd0 : (tick ? ((sec_q == 6'd59) ? 6'd0 : sec_q + 6'd1) : sec_q);
    led_d   = led_q ^ tick;
    time_d  = now_t;
    alarm_d = alarm_q;
    en_d    = en_q;
    is_up   = (btn == B_UP);
    is_dn   = (btn == B_DOWN);
    if (is_up || is_dn) begin
      case (mode_q)
        SET_TH:  time_d.hh = hr_step(time_q.hh, is_up);
        SET_TM:  time_d.mm = mn_step(time_q.mm, is_up);
        SET_AH:  alarm_d[sel_q].hh = hr_step(alarm_q[sel_q].hh, is_up);
        SET_AM:  alarm_d[sel_q].mm = mn_step(alarm_q[sel_q].mm, is_up);
        default: if (is_dn && !ring_q) en_d[sel_q] = !en_q[sel_q];
      endcase
    end
  end

`ifdef ALARM_SNOOZE_EN
  logic       snz_act_q, snz_act_d;
  logic [5:0] snz_cnt_q, snz_cnt_d;
  localparam logic [5:0] SNZ_LD = 6'(SNOOZE_MIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      snz_act_q <= 1'b0;
      snz_cnt_q <= '0;
    end else begin
      snz_act_q <= snz_act_d;
      snz_cnt_q <= snz_cnt_d;
    end
  end
`endif

  always_comb begin
    ring_d  = ring_q;
    src_d   = src_q;
    rcnt_d  = rcnt_q;
    silence = (mode_q == NORMAL) && ring_q && (btn == B_CENTER || btn == B_UP);
    if (ring_q) begin
      if (roll) begin
        if (rcnt_q == 6'd1) ring_d = 1'b0;
        else                rcnt_d = rcnt_q - 6'd1;
      end
    end else if (fire) begin
      ring_d = 1'b1;
      src_d  = fire_src;
      rcnt_d = RING_LD;
    end
`ifdef ALARM_SNOOZE_EN
    snz_act_d = snz_act_q;
    snz_cnt_d = snz_cnt_q;
    // A fresh fire supersedes a pending snooze; expiry re-rings the previous source.
    if (!ring_q) begin
      if (fire) snz_act_d = 1'b0;
      else if (snz_act_q && roll) begin
        if (snz_cnt_q == 6'd1) begin
          ring_d    = 1'b1;
          rcnt_d    = RING_LD;
          snz_act_d = 1'b0;
        end else snz_cnt_d = snz_cnt_q - 6'd1;
      end
    end
    if (silence && btn == B_UP) begin
      snz_act_d = 1'b1;
      snz_cnt_d = SNZ_LD;
    end
    if (btn == B_CENTER) snz_act_d = 1'b0;
`endif
    if (silence) ring_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      blink_q <= '0;
      sec_q   <= '0;
      time_q  <= '0;
      alarm_q <= '0;
      en_q    <= '0;
      led_q   <= 1'b0;
      ring_q  <= 1'b0;
      src_q   <= '0;
      rcnt_q  <= '0;
    end else begin
      presc_q <= presc_d;
      blink_q <= blink_d;
      sec_q   <= sec_d;
      time_q  <= time_d;
      alarm_q <= alarm_d;
      en_q    <= en_d;
      led_q   <= led_d;
      ring_q  <= ring_d;
      src_q   <= src_d;
      rcnt_q  <= rcnt_d;
    end
  end

  always_comb begin
    shown = (mode_q == SET_AH || mode_q == SET_AM) ? alarm_q[sel_q] : time_q;
    case (mode_q)
      SET_TH, SET_AH: mask = 4'b1100;
      SET_TM, SET_AM: mask = 4'b0011;
      default:        mask = 4'b0000;
    endcase
    bus.blink_mask = (blink_q >= P_HALF) ? mask : 4'b0000;
    bus.disp_h1    = 2'(shown.hh / 5'd10);
    bus.disp_h2    = 4'(shown.hh % 5'd10);
    bus.disp_m1    = 3'(shown.mm / 6'd10);
    bus.disp_m2    = 4'(shown.mm % 6'd10);
  end

  assign bus.sec_led   = led_q;
  assign bus.mode      = mode_q;
  assign bus.sel_alarm = sel_q;
  assign bus.alarm_en  = en_q;
  assign bus.ring      = ring_q;
  assign bus.ring_src  = src_q;
endmodule

// File: tb/tb_alarm_clock_core.sv
// Random + directed bench for alarm_clock_core against a seconds-of-day reference model.
module tb_alarm_clock_core;
  localparam int TPS = 4, NA = 2, RMIN = 1, SMIN = 2;
  localparam logic [4:0] B_C = 5'b10000, B_R = 5'b01000, B_L = 5'b00100,
                         B_U = 5'b00010, B_D = 5'b00001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alarm_clock_if #(.NUM_ALARMS(NA)) bus ();
  alarm_clock_core #(.TICKS_PER_SEC(TPS), .NUM_ALARMS(NA), .RING_MIN(RMIN), .SNOOZE_MIN(SMIN))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0, n_err = 0;

  // Reference state: time as seconds of day, alarms as minutes of day.
  int m_tsec, m_pres, m_blk, m_mode, m_sel, m_src, m_rcnt, m_scnt;
  int m_alm[NA];
  bit m_en[NA];
  bit m_ring, m_led, m_snz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic mstep(input logic [4:0] b, input bit r);
    int om, os, h, m, ah, am, hit, act;
    bit oring, roll;
    if (r) begin
      m_tsec = 0; m_pres = 0; m_blk = 0; m_mode = 0; m_sel = 0; m_src = 0;
      m_rcnt = 0; m_scnt = 0; m_ring = 0; m_led = 0; m_snz = 0;
      for (int k = 0; k < NA; k++) begin m_alm[k] = 0; m_en[k] = 0; end
      return;
    end
    om = m_mode; os = m_sel; oring = m_ring; roll = 0;
    m_blk = (m_blk + 1) % TPS;
    if (om == 1 || om == 2) begin
      m_pres = 0; m_tsec = m_tsec / 60 * 60;
    end else if (m_pres == TPS - 1) begin
      m_pres = 0; m_tsec = (m_tsec + 1) % 86400; m_led = !m_led; roll = (m_tsec % 60 == 0);
    end else m_pres++;
    hit = -1;
    if (roll) for (int k = NA - 1; k >= 0; k--) if (m_en[k] && m_alm[k] == m_tsec / 60) hit = k;
    if (oring) begin
      if (roll) begin m_rcnt--; if (m_rcnt == 0) m_ring = 0; end
    end else if (hit >= 0) begin
      m_ring = 1; m_src = hit; m_rcnt = RMIN; m_snz = 0;
    end
`ifdef ALARM_SNOOZE_EN
    else if (m_snz && roll) begin
      m_scnt--;
      if (m_scnt == 0) begin m_ring = 1; m_rcnt = RMIN; m_snz = 0; end
    end
`endif
    act = b[4] ? 0 : b[3] ? 1 : b[2] ? 2 : b[1] ? 3 : b[0] ? 4 : -1;
    h = m_tsec / 3600; m = (m_tsec / 60) % 60; ah = m_alm[os] / 60; am = m_alm[os] % 60;
    case (act)
      0: begin
        if (om != 0) m_mode = 0;
        else if (oring) m_ring = 0;
        else m_mode = 1;
        m_snz = 0;
      end
      1: case (om)
        1: m_mode = 2;
        2: m_mode = 3;
        3: m_mode = 4;
        4: if (os == NA - 1) begin m_mode = 1; m_sel = 0; end
           else begin m_mode = 3; m_sel = os + 1; end
        default: ;
      endcase
      2: case (om)
        1: begin m_mode = 4; m_sel = NA - 1; end
        2: m_mode = 1;
        3: if (os == 0) m_mode = 2; else begin m_mode = 4; m_sel = os - 1; end
        4: m_mode = 3;
        default: ;
      endcase
      3, 4: begin
        int d;
        d = (act == 3) ? 1 : -1;
        case (om)
          0: if (oring) begin
               if (act == 3) begin
                 m_ring = 0;
`ifdef ALARM_SNOOZE_EN
                 m_snz = 1; m_scnt = SMIN;
`endif
               end
             end else if (act == 3) m_sel = (os + 1) % NA;
             else m_en[os] = !m_en[os];
          1: m_tsec = ((h + d + 24) % 24) * 3600 + m * 60;
          2: m_tsec = h * 3600 + ((m + d + 60) % 60) * 60;
          3: m_alm[os] = ((ah + d + 24) % 24) * 60 + am;
          4: m_alm[os] = ah * 60 + (am + d + 60) % 60;
          default: ;
        endcase
      end
      default: ;
    endcase
  endtask

  task automatic check_all();
    int sh, hh, mm;
    logic [12:0] ed;
    logic [3:0] eb;
    logic [NA-1:0] ee;
    sh = (m_mode >= 3) ? m_alm[m_sel] : m_tsec / 60;
    hh = sh / 60; mm = sh % 60;
    ed = {2'(hh / 10), 4'(hh % 10), 3'(mm / 10), 4'(mm % 10)};
    eb = (m_mode == 1 || m_mode == 3) ? 4'b1100 : (m_mode == 2 || m_mode == 4) ? 4'b0011 : 4'b0000;
    if (m_blk < TPS / 2) eb = 4'b0000;
    for (int k = 0; k < NA; k++) ee[k] = m_en[k];
    chk("dig",   32'({bus.disp_h1, bus.disp_h2, bus.disp_m1, bus.disp_m2}), 32'(ed));
    chk("mode",  32'(bus.mode), 32'(m_mode));
    chk("sel",   32'(bus.sel_alarm), 32'(m_sel));
    chk("en",    32'(bus.alarm_en), 32'(ee));
    chk("ring",  32'(bus.ring), 32'(m_ring));
    chk("src",   32'(bus.ring_src), 32'(m_src));
    chk("led",   32'(bus.sec_led), 32'(m_led));
    chk("blink", 32'(bus.blink_mask), 32'(eb));
  endtask

  task automatic cyc(input logic [4:0] b, input bit r);
    @(negedge clk);
    rst = r;
    {bus.center, bus.right, bus.left, bus.up, bus.down} = b;
    @(posedge clk);
    mstep(b, r);
    #1;
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(5'b0, 1'b0);
  endtask

  task automatic wait_ring(input string tag);
    int n;
    n = 0;
    while (!m_ring && n < 300) begin cyc(5'b0, 1'b0); n++; end
    chk(tag, 32'(bus.ring), 32'd1);
  endtask

  initial begin
    {bus.center, bus.right, bus.left, bus.up, bus.down} = 5'b0;
    cyc(5'b0, 1'b1); cyc(5'b0, 1'b1);
    chk("rst_dig", 32'({bus.disp_h1, bus.disp_h2, bus.disp_m1, bus.disp_m2}), 32'd0);
    chk("rst_ring", 32'(bus.ring), 32'd0);

    idle(240);
    chk("min1_dig", 32'({bus.disp_h1, bus.disp_h2, bus.disp_m1, bus.disp_m2}), 32'd1);
    chk("min1_led", 32'(bus.sec_led), 32'd0);

    cyc(B_C, 0); cyc(B_D, 0); cyc(B_R, 0); cyc(B_D, 0); cyc(B_D, 0); cyc(B_C, 0);
    chk("preset_dig", 32'({bus.disp_h1, bus.disp_h2, bus.disp_m1, bus.disp_m2}),
        32'({2'd2, 4'd3, 3'd5, 4'd9}));
    idle(240);
    chk("wrap_dig", 32'({bus.disp_h1, bus.disp_h2, bus.disp_m1, bus.disp_m2}), 32'd0);

    cyc(B_C, 0); cyc(B_D, 0);
    chk("hr_dec_wrap", 32'({bus.disp_h1, bus.disp_h2}), 32'h23);
    cyc(B_R, 0); cyc(B_U, 0);
    chk("min_inc", 32'({bus.disp_m1, bus.disp_m2}), 32'd1);
    cyc(B_C, 0);
    chk("exit_mode", 32'(bus.mode), 32'd0);

    cyc(B_C, 0); cyc(B_L, 0); cyc(B_U, 0); cyc(B_U, 0);
    chk("alm1_show", 32'({bus.sel_alarm, bus.disp_m2}), 32'({1'b1, 4'd2}));
    cyc(B_R, 0); cyc(B_U, 0); cyc(B_C, 0);
    cyc(B_U, 0); cyc(B_D, 0);
    chk("en1", 32'(bus.alarm_en), 32'b10);
    wait_ring("fire1");
    chk("fire1_src", 32'(bus.ring_src), 32'd1);
    chk("fire1_dig", 32'({bus.disp_h1, bus.disp_h2, bus.disp_m1, bus.disp_m2}), 32'd2);
    idle(240);
    chk("auto_sil", 32'(bus.ring), 32'd0);

    cyc(B_C, 0); cyc(B_R, 0); cyc(B_D, 0); cyc(B_D, 0); cyc(B_C, 0);
    wait_ring("fire2");
    cyc(B_C | B_U, 0);
    chk("cu_ring", 32'(bus.ring), 32'd0);
    chk("cu_mode", 32'(bus.mode), 32'd0);
    idle(10);

    cyc(B_C, 0); cyc(B_R, 0); cyc(B_D, 0); cyc(B_C, 0);
    wait_ring("fire3");
    cyc(B_U, 0);
    chk("snz_off", 32'(bus.ring), 32'd0);
    idle(490);
`ifdef ALARM_SNOOZE_EN
    chk("snz_rering", 32'(bus.ring), 32'd1);
`else
    chk("no_snz", 32'(bus.ring), 32'd0);
`endif

    cyc(B_C, 0); cyc(5'b0, 1'b1);
    chk("mid_rst_mode", 32'(bus.mode), 32'd0);
    chk("mid_rst_en", 32'(bus.alarm_en), 32'd0);

    for (int i = 0; i < 4000; i++) begin
      logic [4:0] b;
      b = ($urandom_range(0, 5) == 0) ? 5'($urandom) : 5'b0;
      cyc(b, ($urandom_range(0, 799) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
